// File: rtl/dlfpu_op_scheduler.sv
// -----------------------------------------------------------------------------
// dlfpu_op_scheduler
//   Shares one DL_FPU datapath among NREQ requesters. A combinational
//   round-robin arbiter grants at most one request per cycle. The grant is
//   registered onto the FPU bus. A LAT+1 deep tag pipeline follows every
//   issued op, and each op's result returns in issue order on a registered,
//   id-tagged response bus.
//
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     en                          1 = schedule, 0 = drain in-flight ops and halt
//     req_valid/req_ready         per-requester handshake (ready is the grant)
//     req_op/req_a/req_b          per-requester op select and dlfloat16 operands
//     fpu_ena/fpu_a/fpu_b         registered issue to the FPU (ena one-hot, 0 idle)
//     fpu_result/fpu_exc          FPU return, valid LAT cycles after issue
//     rsp_valid/rsp_id/rsp_result/rsp_exc
//                                 response pulse; rsp_exc[4] flags an illegal op
//     busy                        state != HALT or any op in flight
//     perf_issued/perf_stall      performance counters
//
//   Build option: define DLFPU_SCHED_PERF_EN to build the performance
//   counters. Without it both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module dlfpu_op_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_op,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [3:0]           fpu_ena,
  output logic [15:0]          fpu_a,
  output logic [15:0]          fpu_b,
  input  logic [31:0]          fpu_result,
  input  logic [4:0]           fpu_exc,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_result,
  output logic [4:0]           rsp_exc,
  output logic                 busy,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stall
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  rr_nxt;
  logic            xfer;
  logic [3:0]      win_op;
  logic [15:0]     win_a, win_b;
  logic            win_ill;
  logic            any_tag;

  // Tag pipeline: index 0 is the issue stage, index LAT lines up with the
  // cycle in which fpu_result is valid for that op.
  logic [LAT:0]    tag_vld;
  logic [LAT:0]    tag_ill;
  logic [IDW-1:0]  tag_id [LAT+1];

  // ---- stage p0: arbitration (combinational) ----
  always_comb begin
    logic [IDW:0] sum;
    logic [IDW-1:0] idx;
    xfer = 1'b0;
    win  = '0;
    sum  = '0;
    idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if ((state == S_RUN) && !xfer && req_valid[idx]) begin
        xfer = 1'b1;
        win  = idx;
      end
    end
  end

  assign req_ready = xfer ? (NREQ'(1) << win) : '0;
  assign win_op    = req_op[win*4 +: 4];
  assign win_a     = req_a[win*16 +: 16];
  assign win_b     = req_b[win*16 +: 16];
  assign win_ill   = !$onehot(win_op);
  assign rr_nxt    = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
  assign any_tag   = |tag_vld;
  assign busy      = (state != S_HALT) || any_tag;

  // An en=0 seen in RUN still lets this cycle's grant complete; the
  // drain begins in the following cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (!en) state_nxt = S_DRAIN;
      S_DRAIN: if (en) state_nxt = S_RUN;
               else if (!any_tag) state_nxt = S_HALT;
      S_HALT:  if (en) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // ---- stage p1: issue register, tag shift, response register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      rr         <= '0;
      tag_vld    <= '0;
      fpu_ena    <= 4'b0;
      fpu_a      <= 16'b0;
      fpu_b      <= 16'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= 32'b0;
      rsp_exc    <= 5'b0;
    end else begin
      state   <= state_nxt;
      tag_vld <= {tag_vld[LAT-1:0], xfer};
      fpu_ena <= (xfer && !win_ill) ? win_op : 4'b0;
      if (xfer) begin
        rr    <= rr_nxt;
        fpu_a <= win_a;
        fpu_b <= win_b;
      end
      rsp_valid <= tag_vld[LAT];
      if (tag_vld[LAT]) begin
        rsp_id <= tag_id[LAT];
        // Illegal ops never reached the FPU, so its bus is ignored for them.
        // Bit 4 is owned by the scheduler and is masked off the FPU flags.
        rsp_result <= tag_ill[LAT] ? 32'b0    : fpu_result;
        rsp_exc    <= tag_ill[LAT] ? 5'b10000 : {1'b0, fpu_exc[3:0]};
      end
    end
  end

  // Tag payload needs no reset; it is qualified by tag_vld.
  always_ff @(posedge clk) begin
    tag_id[0]  <= win;
    tag_ill[0] <= win_ill;
    for (int k = 1; k <= LAT; k++) begin
      tag_id[k]  <= tag_id[k-1];
      tag_ill[k] <= tag_ill[k-1];
    end
  end

`ifdef DLFPU_SCHED_PERF_EN
  logic [31:0] issued_q, stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= 32'b0;
      stall_q  <= 32'b0;
    end else begin
      if (xfer) issued_q <= issued_q + 32'd1;
      if ((|req_valid) && !xfer) stall_q <= stall_q + 32'd1;
    end
  end
  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;
`else
  assign perf_issued = 32'b0;
  assign perf_stall  = 32'b0;
`endif

endmodule
